instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: N, 32, instruction width.
REQ-002 Parameter: AW, 32, address width.
REQ-003 Parameter: RESET_PC, 0, first fetch address after reset.
REQ-004 Port: clock  in  1  rising-edge clock.
REQ-005 Port: reset  in  1  reset, synchronous, active-high.
REQ-006 Port: imem_req  out  1  fetch request this cycle; memory always accepts.
REQ-007 Port: imem_addr  out  AW  fetch address, valid when imem_req=1.
REQ-008 Port: imem_rdata  in  N  instruction, valid exactly 1 cycle after an accepted request.
REQ-009 Port: redirect_valid  in  1  branch/jump redirect pulse.
REQ-010 Port: redirect_pc  in  AW  redirect target.
REQ-011 Port: out_valid  out  1  instruction available to the IF/ID stage.
REQ-012 Port: out_instr  out  N  instruction at queue head.
REQ-013 Port: out_pc  out  AW  PC of out_instr.
REQ-014 Port: out_ready  in  1  downstream accepts; transfer when out_valid & out_ready.
REQ-015 Port: fetch_count  out  32  delivered-instruction counter (present only with IFU_PERF_CNT_EN).

Function
REQ-016 States: BOOT, FETCH, HOLD; BOOT lasts exactly one cycle after reset release, imem_req=0, then FETCH.
REQ-017 A 2-entry in-order queue of {pc, instr} buffers returned data; out_valid = occupancy != 0; out_instr/out_pc show the head entry.
REQ-018 The request condition is occupancy + inflight - pop < 2 (inflight 0/1, pop = out_valid & out_ready); FETCH requests when true, HOLD (imem_req=0) when false; HOLD returns to FETCH on the first cycle the condition is true.
REQ-019 Each issued request increments pc by 4 modulo 2^AW (0xFFFFFFFC -> 0x00000000).
REQ-020 Returned imem_rdata is written into the queue at the end of the cycle it is valid, tagged with its request address.
REQ-021 With out_ready held at 1, throughput is one instruction per cycle and request-to-out_valid latency is 2 cycles.
REQ-022 redirect_valid in cycle t: the queue is flushed, any in-flight response is discarded, imem_addr = redirect_pc combinationally with imem_req=1 in t (unless in BOOT), pc <= redirect_pc + 4, out_valid=0 in t+1, and redirect_pc is at the head with out_valid=1 in t+2.
REQ-023 On redirect_valid together with out_valid & out_ready, the redirect wins; the pop does not count as a transfer.
REQ-024 On redirect_valid in BOOT, pc <= redirect_pc and the first request in FETCH uses it.
REQ-025 Queue overflow is impossible by construction; a push and a pop in the same cycle keep occupancy constant.

Reset
REQ-026 When reset=1: state BOOT, pc=RESET_PC, queue empty, inflight cleared, imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fetch_count=0.
REQ-027 Reset overrides redirect_valid and out_ready; reset mid-stream discards the queue and any in-flight response, and no pre-reset data is ever delivered.

Configuration
REQ-028 Macro IFU_PERF_CNT_EN defined: fetch_count exists and increments by 1 per transfer not coincident with redirect_valid, wrapping at 2^32.
REQ-029 Macro IFU_PERF_CNT_EN undefined: port and counter are absent; all other behaviour is identical.

Verification
REQ-030 RESET_PC=0x100, out_ready=1, memory returns data=address: BOOT 1 cycle, then imem_addr 0x100, 0x104, ...; out_valid from 2 cycles after the first request; out_pc/out_instr 0x100, 0x104, ... one per cycle.
REQ-031 out_ready=0 from reset: the queue fills with 0x100 and 0x104, imem_req deasserts (HOLD). Then out_ready=1: 0x100, 0x104, 0x108 are delivered in order with no gaps after the first.
REQ-032 Streaming, redirect_valid=1 with redirect_pc=0x400 in cycle t: imem_addr=0x400 in t, out_valid=0 in t+1, out_pc=0x400 in t+2, then 0x404; no stale addresses appear.
REQ-033 Full queue, out_ready=1 and redirect_valid=1 in the same cycle: fetch_count is unchanged and the next delivered out_pc is redirect_pc.
REQ-034 RESET_PC=0xFFFFFFFC: the second request address is 0x00000000 and out_pc follows.
REQ-035 reset pulsed mid-stream with a full queue: next cycle out_valid=0 and fetch_count=0; the first delivered out_pc after reset release is RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch with a 2-entry {pc, instr} queue and
//               branch redirect. The optional fetch_count port and counter
//               are built only when IFU_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int            N        = 32,
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [N-1:0]  imem_rdata,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  output logic [N-1:0]  out_instr,
  output logic [AW-1:0] out_pc,
  input  logic          out_ready
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]   fetch_count
`endif
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [AW-1:0] c_pc_step = AW'(4);

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [AW-1:0] r_pc;
  logic          r_inflight;
  logic [AW-1:0] r_inflight_pc;
  logic [AW-1:0] r_q_pc    [2];
  logic [N-1:0]  r_q_instr [2];
  logic          r_head;
  logic [1:0]    r_occ;

  logic          w_pop;
  logic          w_push;
  logic          w_room;
  logic          w_tail;

  // Raw pop (before reset gating); reset overrides every update anyway.
  assign w_pop  = (r_occ != 2'd0) & out_ready;
  assign w_room = (({1'b0, r_occ} + {2'b00, r_inflight}) - {2'b00, w_pop}) < 3'd2;
  // A response arriving in a redirect cycle belongs to the abandoned path.
  assign w_push = r_inflight & ~redirect_valid;
  assign w_tail = r_head ^ r_occ[0];

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_BOOT:          w_state_next = S_FETCH;
      S_FETCH, S_HOLD: w_state_next = (redirect_valid | w_room) ? S_FETCH : S_HOLD;
      default:         w_state_next = S_BOOT;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = r_pc;
    if (reset) begin
      imem_addr = RESET_PC;
    end else if (r_state != S_BOOT) begin
      imem_req = redirect_valid | w_room;
      if (redirect_valid) begin
        imem_addr = redirect_pc;
      end
    end
    out_valid = ~reset & (r_occ != 2'd0);
    out_pc    = out_valid ? r_q_pc[r_head]    : '0;
    out_instr = out_valid ? r_q_instr[r_head] : '0;
  end

  // ---------------------------------------------------------------- pc / inflight
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
    end else begin
      if (redirect_valid) begin
        // In BOOT no request goes out, so the target itself is fetched next.
        r_pc <= (r_state == S_BOOT) ? redirect_pc : redirect_pc + c_pc_step;
      end else if (imem_req) begin
        r_pc <= r_pc + c_pc_step;
      end
      r_inflight <= imem_req;
    end
  end

  always_ff @(posedge clock) begin
    r_inflight_pc <= imem_addr;
  end

  // ---------------------------------------------------------------- queue
  always_ff @(posedge clock) begin
    if (reset || redirect_valid) begin
      r_occ  <= 2'd0;
      r_head <= 1'b0;
    end else begin
      r_occ <= (r_occ + {1'b0, w_push}) - {1'b0, w_pop};
      if (w_pop) begin
        r_head <= ~r_head;
      end
    end
  end

  // Occupancy is at most 1 whenever a push lands, so the tail slot is free.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_pc[w_tail]    <= r_inflight_pc;
      r_q_instr[w_tail] <= imem_rdata;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_count <= '0;
    end else if (w_pop && !redirect_valid) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count = reset ? '0 : r_fetch_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Scoreboard bench for instr_fetch_unit (RESET_PC 0x100 and a
//               second instance at 0xFFFFFFFC for address wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam logic [31:0] c_xor = 32'hA5A5_0000;

  logic        clock;
  logic        reset;
  logic        imem_req,   imem_req_w;
  logic [31:0] imem_addr,  imem_addr_w;
  logic [31:0] imem_rdata, imem_rdata_w;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid,  out_valid_w;
  logic [31:0] out_instr,  out_instr_w;
  logic [31:0] out_pc,     out_pc_w;
  logic        out_ready,  ready_w;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count, fetch_count_w;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned exp_cnt  = 0;
  logic [63:0] sb  [$];
  logic [63:0] sbw [$];

  instr_fetch_unit #(.N(32), .AW(32), .RESET_PC(32'h0000_0100)) u_dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready)
`ifdef IFU_PERF_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  instr_fetch_unit #(.N(32), .AW(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clock(clock), .reset(reset),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(out_valid_w), .out_instr(out_instr_w), .out_pc(out_pc_w),
    .out_ready(ready_w)
`ifdef IFU_PERF_CNT_EN
    , .fetch_count(fetch_count_w)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory: always accepts, returns addr ^ c_xor one cycle later.
  always @(posedge clock) begin
    imem_rdata   <= imem_req   ? (imem_addr   ^ c_xor) : 32'hDEAD_BEEF;
    imem_rdata_w <= imem_req_w ? (imem_addr_w ^ c_xor) : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ent(input logic [31:0] pc);
    return {pc, pc ^ c_xor};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Monitor: on every transfer pop the expected entry and compare.
  always @(negedge clock) begin : mon
    logic [63:0] e;
`ifdef IFU_PERF_CNT_EN
    check("fetch_count", fetch_count, reset ? 64'd0 : 64'(exp_cnt));
`endif
    if (reset) begin
      exp_cnt = 0;
    end else if (out_valid && out_ready && !redirect_valid) begin
      exp_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("out_pc", out_pc, e[63:32]);
        check("out_instr", out_instr, e[31:0]);
      end
    end
    if (!reset && out_valid_w && ready_w) begin
      if (sbw.size() == 0) begin
        check("wrap_unexpected_out_pc", out_pc_w, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sbw.pop_front();
        check("wrap_out_pc", out_pc_w, e[63:32]);
        check("wrap_out_instr", out_instr_w, e[31:0]);
      end
    end
  end

  initial begin
    reset = 1'b1; out_ready = 1'b0; ready_w = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) cyc();
    @(negedge clock);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h100);
    check("rst_valid", out_valid, 0);
    check("rst_pc", out_pc, 0);
    check("rst_instr", out_instr, 0);
    check("rst_wrap_addr", imem_addr_w, 32'hFFFF_FFFC);

    // c0: BOOT, streaming with out_ready=1
    cyc(); reset = 1'b0; out_ready = 1'b1; ready_w = 1'b1;
    for (int i = 0; i < 8; i++) sb.push_back(ent(32'h100 + 32'(4 * i)));
    sbw.push_back(ent(32'hFFFF_FFFC));
    sbw.push_back(ent(32'h0000_0000));
    @(negedge clock);
    check("boot_req", imem_req, 0);
    check("boot_wrap_req", imem_req_w, 0);
    cyc(); @(negedge clock);                          // c1
    check("c1_req", imem_req, 1);
    check("c1_addr", imem_addr, 32'h100);
    check("c1_wrap_addr", imem_addr_w, 32'hFFFF_FFFC);
    cyc(); @(negedge clock);                          // c2
    check("c2_addr", imem_addr, 32'h104);
    check("c2_valid", out_valid, 0);
    check("c2_wrap_addr", imem_addr_w, 32'h0);
    cyc(); @(negedge clock);                          // c3
    check("c3_valid", out_valid, 1);
    cyc();                                            // c4
    cyc(); ready_w = 1'b0;                            // c5
    repeat (5) cyc();                                 // c10

    // c11: redirect to 0x400 while streaming
    cyc();
    check("stream_all_delivered", 64'(sb.size()), 0);
    sb.delete();
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    for (int i = 0; i < 4; i++) sb.push_back(ent(32'h400 + 32'(4 * i)));
    @(negedge clock);
    check("redir_req", imem_req, 1);
    check("redir_addr", imem_addr, 32'h400);
    cyc(); redirect_valid = 1'b0; @(negedge clock);   // c12
    check("redir_t1_valid", out_valid, 0);
    check("redir_t1_addr", imem_addr, 32'h404);
    cyc(); @(negedge clock);                          // c13
    check("redir_t2_valid", out_valid, 1);
    check("redir_t2_pc", out_pc, 32'h400);
    repeat (3) cyc();                                 // c16

    // c17: stall, queue fills, HOLD
    cyc();
    check("redir_all_delivered", 64'(sb.size()), 0);
    out_ready = 1'b0;
    sb.push_back(ent(32'h410)); sb.push_back(ent(32'h414)); sb.push_back(ent(32'h418));
    cyc();                                            // c18
    cyc(); @(negedge clock);                          // c19
    check("hold_req_c19", imem_req, 0);
    cyc(); @(negedge clock);                          // c20
    check("hold_req_c20", imem_req, 0);
    check("hold_head_pc", out_pc, 32'h410);
    cyc(); out_ready = 1'b1; @(negedge clock);        // c21
    check("resume_req", imem_req, 1);
    check("resume_addr", imem_addr, 32'h418);
    cyc(); cyc();                                     // c23

    // c24: fill queue, then redirect together with a pop
    cyc();
    check("resume_all_delivered", 64'(sb.size()), 0);
    out_ready = 1'b0;
    cyc();                                            // c25
    cyc();                                            // c26
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h800;
    sb.push_back(ent(32'h800)); sb.push_back(ent(32'h804));
    @(negedge clock);
    check("full_valid", out_valid, 1);
`ifdef IFU_PERF_CNT_EN
    check("full_fetch_count", fetch_count, 15);
`endif
    cyc(); redirect_valid = 1'b0; @(negedge clock);   // c27
    check("pop_redir_valid", out_valid, 0);
`ifdef IFU_PERF_CNT_EN
    check("pop_redir_fetch_count", fetch_count, 15);
`endif
    cyc(); cyc();                                     // c29

    // c30: fill queue, then reset (with a redirect that must be ignored)
    cyc();
    check("pop_redir_all_delivered", 64'(sb.size()), 0);
    out_ready = 1'b0;
    cyc();                                            // c31
    cyc();                                            // c32
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hC00;
    sb.push_back(ent(32'h100)); sb.push_back(ent(32'h104)); sb.push_back(ent(32'h108));
    @(negedge clock);
    check("midrst_valid", out_valid, 0);
    check("midrst_req", imem_req, 0);
    cyc(); reset = 1'b0; redirect_valid = 1'b0; @(negedge clock);  // c33
    check("postrst_valid", out_valid, 0);
    check("postrst_boot_req", imem_req, 0);
`ifdef IFU_PERF_CNT_EN
    check("postrst_fetch_count", fetch_count, 0);
`endif
    cyc(); @(negedge clock);                          // c34
    check("postrst_addr", imem_addr, 32'h100);
    cyc(); cyc();                                     // c36
    cyc(); @(negedge clock);                          // c37
    check("rst_fill_hold_req", imem_req, 0);
    cyc(); out_ready = 1'b1;                          // c38
    cyc(); cyc();                                     // c40

    // c41: stop, reset, then redirect during BOOT
    cyc();
    check("rst_fill_all_delivered", 64'(sb.size()), 0);
    out_ready = 1'b0;
    cyc();                                            // c42
    cyc(); reset = 1'b1;                              // c43
    sb.push_back(ent(32'h2000)); sb.push_back(ent(32'h2004));
    cyc(); reset = 1'b0;                              // c44
    redirect_valid = 1'b1; redirect_pc = 32'h2000; out_ready = 1'b1;
    @(negedge clock);
    check("boot_redir_req", imem_req, 0);
    cyc(); redirect_valid = 1'b0; @(negedge clock);   // c45
    check("boot_redir_addr", imem_addr, 32'h2000);
    check("boot_redir_req2", imem_req, 1);
    cyc(); @(negedge clock);                          // c46
    check("boot_redir_addr2", imem_addr, 32'h2004);
    cyc(); cyc();                                     // c48
    cyc(); out_ready = 1'b0;                          // c49
    cyc(); cyc();
    check("final_sb_empty", 64'(sb.size()), 0);
    check("final_wrap_sb_empty", 64'(sbw.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
